// File: rtl/uart_pkg.sv
// Register map, STATUS bit layout and transmitter FSM encoding shared by the UART TX block.
// Pure declarations: no latency and no backpressure apply here.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // A programmed divisor of zero runs the line at one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Register bus from the bridge plus the UART's serial line and interrupt outputs.
// Wires only: reads are combinational, writes take effect on the next clk edge, no backpressure.
interface uart_tx_if;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        tx;

    modport master (output Addr, WE, Din, input Dout, IRQ, tx);
    modport slave  (input Addr, WE, Din, output Dout, IRQ, tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmitter; rdata shows the head combinationally, push/pop land on the edge.
// No internal backpressure: the caller must not push when full unless it pops in the same cycle.
module uart_tx_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: register file, byte FIFO and 8N1 serialiser.
// Reads are zero-latency; a DATA write to a full FIFO is dropped and flagged as overflow.
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_DIV  = 434
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   bus
);
    import uart_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          we_data, we_status, we_ctrl, we_div;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;

    logic          ovf, ie;
    logic [15:0]   divisor;

    tx_state_t     state, state_nxt;
    logic [15:0]   div_cnt, div_cnt_nxt;
    logic [15:0]   div_lat, div_lat_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          tx_q, tx_nxt;
    logic          irq_q;
    logic          busy, bit_end;
    logic [31:0]   status, rd_dat;
    logic          unused_bus;

    assign we_data   = bus.WE && (bus.Addr[1:0] == REG_DATA);
    assign we_status = bus.WE && (bus.Addr[1:0] == REG_STATUS);
    assign we_ctrl   = bus.WE && (bus.Addr[1:0] == REG_CTRL);
    assign we_div    = bus.WE && (bus.Addr[1:0] == REG_DIV);

    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign fifo_push = we_data && (!fifo_full || fifo_pop);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.Din[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf     <= 1'b0;
            ie      <= 1'b0;
            divisor <= 16'(RESET_DIV);
        end else begin
            if (we_status) begin
                ovf <= 1'b0;
            end else if (we_data && !fifo_push) begin
                ovf <= 1'b1;
            end
            if (we_ctrl) begin
                ie <= bus.Din[0];
            end
            if (we_div) begin
                divisor <= bus.Din[15:0];
            end
        end
    end

    assign busy    = (state != S_IDLE);
    assign bit_end = (div_cnt == div_lat - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            div_lat <= eff_div(16'(RESET_DIV));
            bit_cnt <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            div_lat <= div_lat_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            tx_q    <= tx_nxt;
            irq_q   <= ie && fifo_empty && !busy;
        end
    end

    // tx_nxt is the line level of the state being entered, so tx changes together with state.
    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        div_lat_nxt = div_lat;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        tx_nxt      = tx_q;
        fifo_pop    = 1'b0;
        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    div_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = S_DATA;
                    tx_nxt      = shreg[0];
                end else begin
                    div_cnt_nxt = div_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    div_cnt_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        shreg_nxt   = {1'b0, shreg[7:1]};
                        tx_nxt      = shreg[1];
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    div_cnt_nxt = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        tx_nxt    = 1'b1;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
        // Frame start: the divisor is captured here so later writes only affect later frames.
        if (fifo_pop) begin
            state_nxt   = S_START;
            shreg_nxt   = fifo_rdata;
            div_lat_nxt = eff_div(divisor);
            div_cnt_nxt = '0;
            bit_cnt_nxt = '0;
            tx_nxt      = 1'b0;
        end
    end

    always_comb begin
        status                            = '0;
        status[ST_BUSY]                   = busy;
        status[ST_FULL]                   = fifo_full;
        status[ST_EMPTY]                  = fifo_empty;
        status[ST_OVF]                    = ovf;
        status[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
    end

    always_comb begin
        rd_dat = '0;
        case (bus.Addr[1:0])
            REG_STATUS: rd_dat = status;
            REG_CTRL:   rd_dat = {31'd0, ie};
            REG_DIV:    rd_dat = {16'd0, divisor};
            default:    rd_dat = '0;
        endcase
    end

    assign bus.Dout = rd_dat;
    assign bus.tx   = tx_q;
    assign bus.IRQ  = irq_q;

    assign unused_bus = ^{bus.Addr[29:2], bus.Din[31:16]};

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2): transmit FIFO entries.
REQ-002 SHALL have parameter RESET_DIV, default 434: DIVISOR reset value, in clocks per bit.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Addr  input  30  word address from the bridge; only Addr[1:0] are decoded.
REQ-006 SHALL have port WE  input  1  register write strobe for the current cycle.
REQ-007 SHALL have port Din  input  32  write data.
REQ-008 SHALL have port Dout  output  32  read data.
REQ-009 SHALL have port IRQ  output  1  level interrupt request, wired into HWInt[3].
REQ-010 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-011 SHALL decode registers by Addr[1:0] as follows:
- 0 = DATA (write-only; reads 0).
- 1 = STATUS.
- 2 = CTRL.
- 3 = DIVISOR.
REQ-012 SHALL drive Dout combinationally from Addr with zero-cycle latency, using the same read timing as the timers.
REQ-013 SHALL define STATUS as:
- bit0 = busy (FSM not IDLE).
- bit1 = full.
- bit2 = empty.
- bit3 = overflow (sticky).
- bits[7:4] = FIFO count.
- all other bits read 0.
REQ-014 SHALL push Din[7:0] into the FIFO on WE to DATA; Din[31:8] is ignored.
REQ-015 SHALL drop a DATA write while the FIFO is full and set overflow, unless a pop occurs in the same cycle, in which case the write is accepted.
REQ-016 SHALL clear overflow on any WE to STATUS, regardless of Din.
REQ-017 SHALL use CTRL bit0 as IE; other CTRL bits are read-only zero.
REQ-018 SHALL take DIVISOR from Din[15:0]; a DIVISOR of 0 behaves as 1.
REQ-019 SHALL latch DIVISOR at frame start, so a DIVISOR write mid-frame affects only later frames.
REQ-020 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-021 In IDLE with the FIFO non-empty, SHALL pop the head into the shift register and enter START on the next cycle.
REQ-022 SHALL hold START (tx=0) for DIV cycles, then enter DATA.
REQ-023 SHALL hold DATA for 8 bits of DIV cycles each, LSB first, then enter STOP.
REQ-024 SHALL hold STOP (tx=1) for DIV cycles; it then enters START directly if the FIFO is non-empty (pop on that cycle), else IDLE.
REQ-025 SHALL make a frame exactly 10*DIV cycles, with no idle gap between back-to-back frames.
REQ-026 SHALL drive tx from a register, so it is glitch-free.
REQ-027 SHALL drive IRQ = IE & empty & ~busy, registered with one cycle lag after the condition changes.
REQ-028 SHALL wrap the FIFO pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Reset
REQ-029 On reset SHALL set state IDLE, tx=1, IRQ=0, FIFO empty (count 0), overflow=0, IE=0, DIVISOR=RESET_DIV, and the bit counter and divider counter to 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame, with tx=1 on the cycle after the reset edge; queued bytes are discarded.
REQ-031 Reset SHALL take priority over a simultaneous WE.

Structure
REQ-032 SHALL place the register offsets (DATA/STATUS/CTRL/DIVISOR), the STATUS bit positions, and the FSM state encoding in shared package uart_pkg.
REQ-033 SHALL implement the FIFO as sub-module uart_tx_fifo, with ports clk, reset, push, pop, wdata[7:0], rdata[7:0], full, empty, count.
REQ-034 SHALL keep the top-level register file and FSM in uart_tx.
REQ-035 The bridge SHALL map the block at 0x0000_7F30..0x0000_7F3F; that decode is not part of this block.

Verification
REQ-036 Scenario SHALL cover DIVISOR=4, write DATA 0x55 -> tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then high 4 cycles; busy=1 for 40 cycles.
REQ-037 Scenario SHALL cover DIVISOR=2, five back-to-back DATA writes with FIFO_DEPTH=4 -> the first pops immediately, all five sent in 100 contiguous cycles, overflow=0.
REQ-038 Scenario SHALL cover a DATA write while full with no pop -> byte dropped, STATUS bit3=1, count stays 4; a STATUS write -> bit3=0.
REQ-039 Scenario SHALL cover IE=1 with one byte at DIVISOR=1 -> IRQ=0 during the frame and IRQ=1 one cycle after busy falls; an IE=0 write -> IRQ=0 next cycle.
REQ-040 Scenario SHALL cover reset asserted in DATA state of bit 3 -> next cycle tx=1, STATUS=0x00000004, DIVISOR reads 434.
REQ-041 Scenario SHALL cover DIVISOR 0 -> a frame lasts 10 cycles; a DIVISOR write of 8 mid-frame -> the current frame is unchanged and the next frame lasts 80 cycles.
